// File: rtl/commit_ctrl_if.sv
// Commit bundle from the write-back stage plus the retire/flush results
// produced by commit_ctrl.
interface commit_ctrl_if;
  logic [1:0]  commit_valid;
  logic [5:0]  is_exception1;
  logic [5:0]  is_exception2;
  logic [41:0] cause1;
  logic [41:0] cause2;
  logic [31:0] commit_pc1;
  logic [31:0] commit_pc2;
  logic [31:0] commit_addr1;
  logic [31:0] commit_addr2;
  logic [1:0]  commit_idle;
  logic [1:0]  commit_ertn;
  logic [1:0]  reg_we;
  logic [4:0]  reg_waddr1;
  logic [4:0]  reg_waddr2;
  logic [31:0] reg_wdata1;
  logic [31:0] reg_wdata2;
  logic [1:0]  csr_we;
  logic [13:0] csr_addr1;
  logic [13:0] csr_addr2;
  logic [31:0] csr_wdata1;
  logic [31:0] csr_wdata2;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        interrupt;

  logic [1:0]  rf_we_o;
  logic [4:0]  rf_waddr1_o;
  logic [4:0]  rf_waddr2_o;
  logic [31:0] rf_wdata1_o;
  logic [31:0] rf_wdata2_o;
  logic [1:0]  csr_we_o;
  logic [13:0] csr_addr1_o;
  logic [13:0] csr_addr2_o;
  logic [31:0] csr_wdata1_o;
  logic [31:0] csr_wdata2_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        exc_valid_o;
  logic [6:0]  exc_cause_o;
  logic [31:0] exc_era_o;
  logic [31:0] exc_badv_o;
  logic        ertn_o;
  logic        idle_o;

  modport master (
    output commit_valid, is_exception1, is_exception2, cause1, cause2,
           commit_pc1, commit_pc2, commit_addr1, commit_addr2,
           commit_idle, commit_ertn, reg_we, reg_waddr1, reg_waddr2,
           reg_wdata1, reg_wdata2, csr_we, csr_addr1, csr_addr2,
           csr_wdata1, csr_wdata2, csr_eentry, csr_era, interrupt,
    input  rf_we_o, rf_waddr1_o, rf_waddr2_o, rf_wdata1_o, rf_wdata2_o,
           csr_we_o, csr_addr1_o, csr_addr2_o, csr_wdata1_o, csr_wdata2_o,
           flush_o, new_pc_o, exc_valid_o, exc_cause_o, exc_era_o,
           exc_badv_o, ertn_o, idle_o
  );

  modport slave (
    input  commit_valid, is_exception1, is_exception2, cause1, cause2,
           commit_pc1, commit_pc2, commit_addr1, commit_addr2,
           commit_idle, commit_ertn, reg_we, reg_waddr1, reg_waddr2,
           reg_wdata1, reg_wdata2, csr_we, csr_addr1, csr_addr2,
           csr_wdata1, csr_wdata2, csr_eentry, csr_era, interrupt,
    output rf_we_o, rf_waddr1_o, rf_waddr2_o, rf_wdata1_o, rf_wdata2_o,
           csr_we_o, csr_addr1_o, csr_addr2_o, csr_wdata1_o, csr_wdata2_o,
           flush_o, new_pc_o, exc_valid_o, exc_cause_o, exc_era_o,
           exc_badv_o, ertn_o, idle_o
  );
endinterface

// File: rtl/commit_ctrl.sv
// Dual-issue commit controller: picks which slots retire in program order,
// raises exception/ertn/idle flushes with a redirect PC, and parks in IDLE
// until an interrupt arrives. All outputs are registered.
module commit_ctrl #(
  parameter logic [6:0] INT_CAUSE = 7'h00
) (
  input logic          clk,
  input logic          rst,
  commit_ctrl_if.slave bus
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] IDLE = 1'b1;

  logic [0:0]  state, state_n;
  logic [31:0] held_pc, held_pc_n;

  logic [1:0]  rf_we_n, csr_we_n;
  logic        flush_n, exc_valid_n, ertn_n;
  logic [31:0] new_pc_n, era_n, badv_n;
  logic [6:0]  exc_cause_n;
  logic        slot2_eval, slot2_int;
  logic [31:0] pc1_inc, pc2_inc;

  assign pc1_inc = bus.commit_pc1 + 32'd4;
  assign pc2_inc = bus.commit_pc2 + 32'd4;

  // Cause of the highest-priority flagged stage; later (higher) bits overwrite.
  function automatic logic [6:0] pick_cause(input logic [5:0] flags, input logic [41:0] causes);
    logic [6:0] r;
    r = '0;
    for (int unsigned k = 0; k < 6; k++) begin
      if (flags[k]) r = causes[k*7 +: 7];
    end
    return r;
  endfunction

  // Retire/flush decision for the current commit bundle.
  always_comb begin
    state_n     = state;
    held_pc_n   = held_pc;
    rf_we_n     = '0;
    csr_we_n    = '0;
    flush_n     = 1'b0;
    new_pc_n    = '0;
    exc_valid_n = 1'b0;
    exc_cause_n = '0;
    era_n       = '0;
    badv_n      = '0;
    ertn_n      = 1'b0;
    slot2_eval  = 1'b0;
    slot2_int   = 1'b0;
    // The bundle following a flush belongs to squashed younger instructions.
    if (!bus.flush_o) begin
      if (state == IDLE) begin
        if (bus.interrupt) begin
          exc_valid_n = 1'b1;
          exc_cause_n = INT_CAUSE;
          era_n       = held_pc;
          new_pc_n    = bus.csr_eentry;
          flush_n     = 1'b1;
          state_n     = RUN;
        end
      end else if (bus.commit_valid[0]) begin
        if (bus.interrupt) begin
          exc_valid_n = 1'b1;
          exc_cause_n = INT_CAUSE;
          era_n       = bus.commit_pc1;
          new_pc_n    = bus.csr_eentry;
          flush_n     = 1'b1;
        end else if (|bus.is_exception1) begin
          exc_valid_n = 1'b1;
          exc_cause_n = pick_cause(bus.is_exception1, bus.cause1);
          era_n       = bus.commit_pc1;
          badv_n      = bus.is_exception1[5] ? bus.commit_pc1 : bus.commit_addr1;
          new_pc_n    = bus.csr_eentry;
          flush_n     = 1'b1;
        end else begin
          rf_we_n[0]  = bus.reg_we[0];
          csr_we_n[0] = bus.csr_we[0];
          if (bus.commit_ertn[0]) begin
            ertn_n   = 1'b1;
            new_pc_n = bus.csr_era;
            flush_n  = 1'b1;
          end else if (bus.commit_idle[0]) begin
            new_pc_n  = pc1_inc;
            held_pc_n = pc1_inc;
            flush_n   = 1'b1;
            state_n   = IDLE;
          end else begin
            slot2_eval = 1'b1;
          end
        end
      end else begin
        // Slot 2 stands alone and is therefore also the interrupt victim.
        slot2_eval = 1'b1;
        slot2_int  = 1'b1;
      end

      if (slot2_eval && bus.commit_valid[1]) begin
        if (slot2_int && bus.interrupt) begin
          exc_valid_n = 1'b1;
          exc_cause_n = INT_CAUSE;
          era_n       = bus.commit_pc2;
          new_pc_n    = bus.csr_eentry;
          flush_n     = 1'b1;
        end else if (|bus.is_exception2) begin
          exc_valid_n = 1'b1;
          exc_cause_n = pick_cause(bus.is_exception2, bus.cause2);
          era_n       = bus.commit_pc2;
          badv_n      = bus.is_exception2[5] ? bus.commit_pc2 : bus.commit_addr2;
          new_pc_n    = bus.csr_eentry;
          flush_n     = 1'b1;
        end else begin
          rf_we_n[1]  = bus.reg_we[1];
          csr_we_n[1] = bus.csr_we[1];
          if (bus.commit_ertn[1]) begin
            ertn_n   = 1'b1;
            new_pc_n = bus.csr_era;
            flush_n  = 1'b1;
          end else if (bus.commit_idle[1]) begin
            new_pc_n  = pc2_inc;
            held_pc_n = pc2_inc;
            flush_n   = 1'b1;
            state_n   = IDLE;
          end
        end
      end
    end
  end

  // Register state and every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RUN;
      held_pc          <= '0;
      bus.rf_we_o      <= '0;
      bus.rf_waddr1_o  <= '0;
      bus.rf_waddr2_o  <= '0;
      bus.rf_wdata1_o  <= '0;
      bus.rf_wdata2_o  <= '0;
      bus.csr_we_o     <= '0;
      bus.csr_addr1_o  <= '0;
      bus.csr_addr2_o  <= '0;
      bus.csr_wdata1_o <= '0;
      bus.csr_wdata2_o <= '0;
      bus.flush_o      <= 1'b0;
      bus.new_pc_o     <= '0;
      bus.exc_valid_o  <= 1'b0;
      bus.exc_cause_o  <= '0;
      bus.exc_era_o    <= '0;
      bus.exc_badv_o   <= '0;
      bus.ertn_o       <= 1'b0;
      bus.idle_o       <= 1'b0;
    end else begin
      state            <= state_n;
      held_pc          <= held_pc_n;
      bus.rf_we_o      <= rf_we_n;
      bus.rf_waddr1_o  <= bus.reg_waddr1;
      bus.rf_waddr2_o  <= bus.reg_waddr2;
      bus.rf_wdata1_o  <= bus.reg_wdata1;
      bus.rf_wdata2_o  <= bus.reg_wdata2;
      bus.csr_we_o     <= csr_we_n;
      bus.csr_addr1_o  <= bus.csr_addr1;
      bus.csr_addr2_o  <= bus.csr_addr2;
      bus.csr_wdata1_o <= bus.csr_wdata1;
      bus.csr_wdata2_o <= bus.csr_wdata2;
      bus.flush_o      <= flush_n;
      bus.new_pc_o     <= new_pc_n;
      bus.exc_valid_o  <= exc_valid_n;
      bus.exc_cause_o  <= exc_cause_n;
      bus.exc_era_o    <= era_n;
      bus.exc_badv_o   <= badv_n;
      bus.ertn_o       <= ertn_n;
      bus.idle_o       <= (state_n == IDLE);
    end
  end

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: table of commit bundles with expected results,
// plus an IDLE/wake/reset sequence.
module tb_commit_ctrl;

  localparam logic [6:0]  INTC   = 7'h2A;
  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  commit_ctrl_if bus();
  commit_ctrl #(.INT_CAUSE(INTC)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [5:0]  ex1, ex2;
    logic [41:0] c1, c2;
    logic [31:0] pc1, pc2, ad1, ad2;
    logic [1:0]  idle, ertn, rwe, cwe;
    logic        intr;
    logic [1:0]  e_rf, e_csr;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_exc;
    logic [6:0]  e_cause;
    logic [31:0] e_era, e_badv;
    logic        e_ertn, e_idle;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t base(input string nm);
    vec_t v;
    v.name = nm; v.valid = 2'b11; v.ex1 = '0; v.ex2 = '0; v.c1 = '0; v.c2 = '0;
    v.pc1 = 32'h1c000000; v.pc2 = 32'h1c000004; v.ad1 = '0; v.ad2 = '0;
    v.idle = '0; v.ertn = '0; v.rwe = 2'b11; v.cwe = '0; v.intr = 1'b0;
    v.e_rf = '0; v.e_csr = '0; v.e_flush = 1'b0; v.e_pc = '0; v.e_exc = 1'b0;
    v.e_cause = '0; v.e_era = '0; v.e_badv = '0; v.e_ertn = 1'b0; v.e_idle = 1'b0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.commit_valid = v.valid; bus.is_exception1 = v.ex1; bus.is_exception2 = v.ex2;
    bus.cause1 = v.c1; bus.cause2 = v.c2; bus.commit_pc1 = v.pc1; bus.commit_pc2 = v.pc2;
    bus.commit_addr1 = v.ad1; bus.commit_addr2 = v.ad2; bus.commit_idle = v.idle;
    bus.commit_ertn = v.ertn; bus.reg_we = v.rwe; bus.csr_we = v.cwe; bus.interrupt = v.intr;
  endtask

  task automatic compare(input vec_t e);
    chk({e.name, ".rf_we"}, 32'(bus.rf_we_o), 32'(e.e_rf));
    chk({e.name, ".csr_we"}, 32'(bus.csr_we_o), 32'(e.e_csr));
    chk({e.name, ".flush"}, 32'(bus.flush_o), 32'(e.e_flush));
    chk({e.name, ".exc_valid"}, 32'(bus.exc_valid_o), 32'(e.e_exc));
    chk({e.name, ".ertn"}, 32'(bus.ertn_o), 32'(e.e_ertn));
    chk({e.name, ".idle"}, 32'(bus.idle_o), 32'(e.e_idle));
    if (e.e_flush) chk({e.name, ".new_pc"}, bus.new_pc_o, e.e_pc);
    if (e.e_exc) begin
      chk({e.name, ".cause"}, 32'(bus.exc_cause_o), 32'(e.e_cause));
      chk({e.name, ".era"}, bus.exc_era_o, e.e_era);
      chk({e.name, ".badv"}, bus.exc_badv_o, e.e_badv);
    end
    if (e.e_rf[0]) begin
      chk({e.name, ".waddr1"}, 32'(bus.rf_waddr1_o), 32'd5);
      chk({e.name, ".wdata1"}, bus.rf_wdata1_o, 32'h11);
    end
    if (e.e_rf[1]) begin
      chk({e.name, ".waddr2"}, 32'(bus.rf_waddr2_o), 32'd6);
      chk({e.name, ".wdata2"}, bus.rf_wdata2_o, 32'h22);
    end
    if (e.e_csr[0]) begin
      chk({e.name, ".csr_addr1"}, 32'(bus.csr_addr1_o), 32'h006);
      chk({e.name, ".csr_wdata1"}, bus.csr_wdata1_o, 32'hAA);
    end
    if (e.e_csr[1]) begin
      chk({e.name, ".csr_addr2"}, 32'(bus.csr_addr2_o), 32'h007);
      chk({e.name, ".csr_wdata2"}, bus.csr_wdata2_o, 32'hBB);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare(e);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, ".rf_we"}, 32'(bus.rf_we_o), 32'd0);
    chk({nm, ".csr_we"}, 32'(bus.csr_we_o), 32'd0);
    chk({nm, ".flush"}, 32'(bus.flush_o), 32'd0);
    chk({nm, ".new_pc"}, bus.new_pc_o, 32'd0);
    chk({nm, ".exc_valid"}, 32'(bus.exc_valid_o), 32'd0);
    chk({nm, ".era"}, bus.exc_era_o, 32'd0);
    chk({nm, ".ertn"}, 32'(bus.ertn_o), 32'd0);
    chk({nm, ".idle"}, 32'(bus.idle_o), 32'd0);
    chk({nm, ".wdata1"}, bus.rf_wdata1_o, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    bus.reg_waddr1 = 5'd5; bus.reg_waddr2 = 5'd6;
    bus.reg_wdata1 = 32'h11; bus.reg_wdata2 = 32'h22;
    bus.csr_addr1 = 14'h006; bus.csr_addr2 = 14'h007;
    bus.csr_wdata1 = 32'hAA; bus.csr_wdata2 = 32'hBB;
    bus.csr_eentry = EENTRY; bus.csr_era = ERA;
    drive(base("idle_inputs"));
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    v = base("pair");                v.e_rf = 2'b11; tbl.push_back(v);
    v = base("s1_exc");              v.pc1 = 32'h1c000010; v.ex1 = 6'b000110;
    v.c1 = {7'h00, 7'h00, 7'h33, 7'h0D, 7'h09, 7'h00};
    v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = 7'h0D;
    v.e_era = 32'h1c000010; v.e_badv = 32'h0; tbl.push_back(v);
    v = base("mask_after_exc");      tbl.push_back(v);
    v = base("s2_exc_pc");           v.pc2 = 32'h1c000024; v.ex2 = 6'b100001; v.ad2 = 32'hdead;
    v.c2 = {7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06};
    v.e_rf = 2'b01; v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = 7'h01;
    v.e_era = 32'h1c000024; v.e_badv = 32'h1c000024; tbl.push_back(v);
    v = base("mask_after_s2exc");    tbl.push_back(v);
    v = base("s1_ertn");             v.ertn = 2'b01; v.cwe = 2'b11;
    v.e_rf = 2'b01; v.e_csr = 2'b01; v.e_ertn = 1; v.e_flush = 1; v.e_pc = ERA; tbl.push_back(v);
    v = base("mask_after_ertn");     v.cwe = 2'b11; tbl.push_back(v);
    v = base("int_beats_exc");       v.intr = 1; v.ex1 = 6'b111111; v.pc1 = 32'h1c000040; v.ad1 = 32'h55;
    v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = INTC;
    v.e_era = 32'h1c000040; v.e_badv = 32'h0; tbl.push_back(v);
    v = base("mask_after_int");      v.intr = 1; tbl.push_back(v);
    v = base("int_on_slot2");        v.valid = 2'b10; v.intr = 1; v.pc2 = 32'h1c000084;
    v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = INTC;
    v.e_era = 32'h1c000084; v.e_badv = 32'h0; tbl.push_back(v);
    v = base("mask_after_int2");     tbl.push_back(v);
    v = base("s2_alone");            v.valid = 2'b10; v.e_rf = 2'b10; tbl.push_back(v);
    v = base("s2_exc_addr");         v.rwe = 2'b00; v.cwe = 2'b11; v.ex2 = 6'b000010; v.ad2 = 32'h1234;
    v.c2 = {7'h11, 7'h12, 7'h13, 7'h14, 7'h09, 7'h16};
    v.e_csr = 2'b01; v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = 7'h09;
    v.e_era = 32'h1c000004; v.e_badv = 32'h1234; tbl.push_back(v);
    v = base("mask_after_s2exc2");   tbl.push_back(v);
    v = base("s2_ertn");             v.ertn = 2'b10; v.e_rf = 2'b11; v.e_ertn = 1; v.e_flush = 1; v.e_pc = ERA;
    tbl.push_back(v);
    v = base("mask_after_s2ertn");   tbl.push_back(v);
    v = base("int_no_valid");        v.valid = 2'b00; v.intr = 1; tbl.push_back(v);
    v = base("invalid_s1_flags");    v.valid = 2'b10; v.ex1 = 6'b111111; v.ertn = 2'b01; v.e_rf = 2'b10;
    tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i]);

    // IDLE entry, ignored inputs, interrupt wake-up.
    v = base("s1_idle");      v.pc1 = 32'h1c000200; v.idle = 2'b01;
    v.e_rf = 2'b01; v.e_flush = 1; v.e_pc = 32'h1c000204; v.e_idle = 1; apply(v);
    for (int i = 0; i < 10; i++) begin
      v = base("idle_hold"); v.ertn = 2'b01; v.e_idle = 1; apply(v);
    end
    v = base("idle_wake");    v.intr = 1;
    v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = INTC;
    v.e_era = 32'h1c000204; v.e_badv = 32'h0; apply(v);
    v = base("mask_after_wake"); v.intr = 1; apply(v);

    // PC+4 wrap, then asynchronous reset while parked.
    v = base("idle_wrap");    v.valid = 2'b01; v.pc1 = 32'hFFFFFFFC; v.idle = 2'b01;
    v.e_rf = 2'b01; v.e_flush = 1; v.e_pc = 32'h0; v.e_idle = 1; apply(v);
    for (int i = 0; i < 2; i++) begin
      v = base("idle_wrap_hold"); v.e_idle = 1; apply(v);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst = 1'b0;
    v = base("after_reset");  v.e_rf = 2'b11; apply(v);
    v = base("after_reset_int"); v.intr = 1; v.pc1 = 32'h1c000300;
    v.e_exc = 1; v.e_flush = 1; v.e_pc = EENTRY; v.e_cause = INTC;
    v.e_era = 32'h1c000300; v.e_badv = 32'h0; apply(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
